// File: rtl/pipe_stage_reg_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_stage_reg_pkg : shared field widths and the "no register" ID     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_stage_reg_pkg;

  localparam int OP_W   = 6;
  localparam int FUNC_W = 6;
  localparam int WORD_W = 32;

  // Payload is op + func + valC/valA/valB.
  localparam int DATA_W_DEF = OP_W + FUNC_W + 3 * WORD_W;
  localparam int NREG_DEF   = 4;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  localparam logic [REG_W_DEF-1:0] RNONE = 5'h0F;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones, sync reset          |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------+
// | pipe_stage_reg : pipeline stage register with stall/bubble control    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                NREG    = NREG_DEF,
  parameter int                REG_W   = REG_W_DEF,
  parameter logic [REG_W-1:0]  RNONE_V = RNONE,
  parameter int                CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  bubble,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [NREG*REG_W-1:0] in_regs,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [NREG*REG_W-1:0] out_regs,
  output logic                  conflict,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic [NREG*REG_W-1:0] regs_none;
  logic                  stall_inc;

  assign regs_none = {NREG{RNONE_V}};
  // A stall masked by a bubble is not counted as a stall.
  assign stall_inc = stall & ~bubble;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_regs  <= regs_none;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_regs  <= in_regs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if (stall && bubble) begin
      conflict <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble),
    .count (bubble_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a CNT_W=2 instance
// for saturation.
`default_nettype none

module tb_pipe_stage_reg;

  localparam int DW = 108;
  localparam int RW = 5;
  localparam int NR = 4;
  localparam logic [RW-1:0]    RN       = 5'h0F;
  localparam logic [NR*RW-1:0] RN_LANES = {RN, RN, RN, RN};

  logic            clk = 1'b0;
  logic            reset, stall, bubble, in_valid, stall2;
  logic [DW-1:0]   in_data;
  logic [NR*RW-1:0] in_regs;
  logic            out_valid, conflict;
  logic [DW-1:0]   out_data;
  logic [NR*RW-1:0] out_regs;
  logic [15:0]     stall_cnt, bubble_cnt;

  logic            o2_valid, o2_conflict;
  logic [DW-1:0]   o2_data;
  logic [NR*RW-1:0] o2_regs;
  logic [1:0]      s2_cnt, b2_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_data(in_data), .in_regs(in_regs),
    .out_valid(out_valid), .out_data(out_data), .out_regs(out_regs),
    .conflict(conflict), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall2), .bubble(1'b0),
    .in_valid(1'b1), .in_data(108'h77), .in_regs(20'h0),
    .out_valid(o2_valid), .out_data(o2_data), .out_regs(o2_regs),
    .conflict(o2_conflict), .stall_cnt(s2_cnt), .bubble_cnt(b2_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [NR*RW-1:0] r, input logic c,
                           input logic [15:0] sc, input logic [15:0] bc);
    check({tag, ".valid"},    128'(out_valid),  128'(v));
    check({tag, ".data"},     128'(out_data),   128'(d));
    check({tag, ".regs"},     128'(out_regs),   128'(r));
    check({tag, ".conflict"}, 128'(conflict),   128'(c));
    check({tag, ".stall_cnt"},  128'(stall_cnt),  128'(sc));
    check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(bc));
  endtask

  initial begin
    logic [1:0] sat_exp [6];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    reset = 1'b1; stall = 1'b0; bubble = 1'b0; stall2 = 1'b0;
    in_valid = 1'b1; in_data = 108'hDEAD; in_regs = 20'hABCDE;
    step();
    check_all("reset", 1'b0, '0, RN_LANES, 1'b0, 16'd0, 16'd0);
    check("reset.cnt2", 128'(s2_cnt), 128'd0);

    // load: lanes {3,4,5,6}, lane 0 in the LSBs
    reset = 1'b0;
    in_valid = 1'b1; in_data = 108'h1234;
    in_regs = {5'd6, 5'd5, 5'd4, 5'd3};
    step();
    check_all("load", 1'b1, 108'h1234, {5'd6, 5'd5, 5'd4, 5'd3}, 1'b0, 16'd0, 16'd0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 108'h9000 + 108'(i);
      in_regs = 20'(i * 7 + 1);
      in_valid = 1'b0;
      step();
    end
    check_all("stall3", 1'b1, 108'h1234, {5'd6, 5'd5, 5'd4, 5'd3}, 1'b0, 16'd3, 16'd0);

    stall = 1'b0; bubble = 1'b1; in_valid = 1'b1; in_data = 108'h5555;
    step();
    check_all("bubble", 1'b0, '0, RN_LANES, 1'b0, 16'd3, 16'd1);

    // invalid load still captures payload
    bubble = 1'b0; in_valid = 1'b0; in_data = 108'hABCD; in_regs = {5'd1, 5'd2, 5'd3, 5'd4};
    step();
    check_all("load_inv", 1'b0, 108'hABCD, {5'd1, 5'd2, 5'd3, 5'd4}, 1'b0, 16'd3, 16'd1);

    stall = 1'b1; bubble = 1'b1; in_valid = 1'b1; in_data = 108'h42;
    step();
    check_all("conflict", 1'b0, '0, RN_LANES, 1'b1, 16'd3, 16'd2);

    stall = 1'b0; bubble = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 108'h100 + 108'(i);
      in_regs = 20'(i + 100);
      step();
    end
    check_all("sticky", 1'b1, 108'h109, 20'd109, 1'b1, 16'd3, 16'd2);

    stall2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("sat%0d", i), 128'(s2_cnt), 128'(sat_exp[i]));
    end
    stall2 = 1'b0;

    // reset with stall, counters nonzero
    reset = 1'b1; stall = 1'b1;
    step();
    check_all("rst_stall", 1'b0, '0, RN_LANES, 1'b0, 16'd0, 16'd0);
    check("rst_stall.cnt2", 128'(s2_cnt), 128'd0);

    reset = 1'b0; stall = 1'b0; in_valid = 1'b1; in_data = 108'h77AA; in_regs = 20'h12345;
    step();
    check_all("post_rst", 1'b1, 108'h77AA, 20'h12345, 1'b0, 16'd0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
